// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared response-FSM state type and grant-counter width for adder_arbiter
package adder_arb_pkg;
    typedef enum logic {EMPTY, FULL} state_t;
    localparam int CNT_W = 16;
endpackage

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: WIDTH-bit unsigned adder built from generate/propagate terms
//   i_a, i_b operands   i_cin carry in   o_sum sum bits   o_cout carry out
module carry_lookahead_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;
    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;
    always_comb begin
        w_c[0] = i_cin;
        for (int i = 0; i < WIDTH; i++)
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
    assign o_sum  = w_p ^ w_c[WIDTH-1:0];
    assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting the search at i_ptr
//   i_req  requester valids        i_ptr  first index to consider   i_en  allow the grant
//   o_gnt  one-hot grant (0 if none or !i_en)                        o_idx encoded winner
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);
    logic w_found;
    always_comb begin
        int k;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(i_ptr) + i;
            k = (k >= NREQ) ? k - NREQ : k;
            if (!w_found && i_req[k]) begin
                w_found = 1'b1;
                o_idx   = IDW'(k);
            end
        end
        o_gnt[o_idx] = w_found & i_en;
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder among NREQ valid/ready requesters
//   i_clk, i_rst_n (sync, active-low)
//   i_req_valid/o_req_ready/i_req_a/i_req_b  per-requester operand channels (packed by index)
//   o_rsp_valid/i_rsp_ready/o_rsp_id/o_rsp_sum  single registered response {carry, sum}
//   o_grant_cnt  saturating per-requester grant counters, only with ADDER_ARB_STATS_EN
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [IDW-1:0]        o_rsp_id,
`ifdef ADDER_ARB_STATS_EN
    output logic [WIDTH:0]        o_rsp_sum,
    output logic [NREQ*CNT_W-1:0] o_grant_cnt
`else
    output logic [WIDTH:0]        o_rsp_sum
`endif
);
    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_idx;
    logic             w_grant;
    logic             w_can_accept;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // A pop in the same cycle frees the register, so a full slot can still accept
    assign w_can_accept = i_rst_n & ((r_state == EMPTY) | i_rsp_ready);
    assign o_req_ready  = w_gnt;
    assign w_grant      = |w_gnt;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .i_en  (w_can_accept),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    carry_lookahead_adder #(.WIDTH(WIDTH)) u_add (
        .i_a    (i_req_a[w_idx*WIDTH +: WIDTH]),
        .i_b    (i_req_b[w_idx*WIDTH +: WIDTH]),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= EMPTY;
            r_ptr       <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_sum   <= '0;
        end else if (w_grant) begin
            r_state     <= FULL;
            r_ptr       <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
            o_rsp_valid <= 1'b1;
            o_rsp_id    <= w_idx;
            o_rsp_sum   <= {w_cout, w_sum};
        end else if (o_rsp_valid && i_rsp_ready) begin
            r_state     <= EMPTY;
            o_rsp_valid <= 1'b0;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_grant_cnt <= '0;
        else
            for (int k = 0; k < NREQ; k++)
                if (w_gnt[k] && o_grant_cnt[k*CNT_W +: CNT_W] != '1)
                    o_grant_cnt[k*CNT_W +: CNT_W] <= o_grant_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
    end
`endif
endmodule
